// File: rtl/tlu_clk_lock_ctrl.sv
// Lock supervisor and reset sequencer for the cascaded clock-generation DCMs.
// It pulses the DCM reset, waits for LOCKED, holds the fast-domain reset until
// lock has been stable for the settle time, retries on timeout, and counts
// lock losses seen while running.
module tlu_clk_lock_ctrl #(
    parameter int RST_PULSE_CYCLES = 8,
    parameter int LOCK_TIMEOUT     = 4096,
    parameter int SETTLE_CYCLES    = 256,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       BUS_CLK,
    input  logic       BUS_RST,
    input  logic       LOCKED_IN,
    input  logic       FORCE_RESET,
    output logic       DCM_RST,
    output logic       SYS_RST,
    output logic       CLK_READY,
    output logic       FAIL,
    output logic [2:0] STATE,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // One counter serves all timed states, so it is sized for the longest one.
    localparam int CNT_MAX0 = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > RST_PULSE_CYCLES) ? CNT_MAX0 : RST_PULSE_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          restart;
    logic          lock_meta, locked_s;
    logic [3:0]    retry_cnt, retry_next;
    logic [7:0]    loss_cnt, loss_next;

    // Two-flop synchronizer for the asynchronous DCM LOCKED status.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= LOCKED_IN;
            locked_s  <= lock_meta;
        end
    end

    // Next-state, retry and loss-count decisions; FORCE_RESET overrides events
    // but a lock loss in the same cycle is still counted.
    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        loss_next  = loss_cnt;
        case (state)
            ST_RESET: begin
                if (cnt == PULSE_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_SETTLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_next = retry_cnt + 4'd1;
                    state_next = (retry_next == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                end
            end
            ST_SETTLE: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt == SETTLE_LAST) begin
                    state_next = ST_RUN;
                    retry_next = 4'd0;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_next = ST_RESET;
                    if (loss_cnt != 8'hFF) loss_next = loss_cnt + 8'd1;
                end
            end
            ST_FAIL: ;
            default: state_next = ST_RESET;
        endcase
        if (FORCE_RESET) begin
            state_next = ST_RESET;
            retry_next = 4'd0;
        end
    end

    // The counter restarts on every state entry, including a forced re-entry of RESET.
    assign restart = FORCE_RESET || (state_next != state);

    // State, counter, counters and registered output decode.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= ST_RESET;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            loss_cnt  <= 8'd0;
            DCM_RST   <= 1'b1;
            SYS_RST   <= 1'b1;
            CLK_READY <= 1'b0;
            FAIL      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= restart ? '0 : cnt + 1'b1;
            retry_cnt <= retry_next;
            loss_cnt  <= loss_next;
            DCM_RST   <= (state_next == ST_RESET);
            SYS_RST   <= (state_next != ST_RUN);
            CLK_READY <= (state_next == ST_RUN);
            FAIL      <= (state_next == ST_FAIL);
        end
    end

    assign STATE     = state;
    assign RETRY_CNT = retry_cnt;
    assign LOSS_CNT  = loss_cnt;

endmodule
